// File: rtl/gui_pkg.sv
// Shared definitions for the GUI screen path: screen-phase encodings, raster
// geometry and the overlay ROM key colour.
package gui_pkg;

    typedef enum logic [1:0] {
        S_TITLE      = 2'd0,
        S_PLAY       = 2'd1,
        S_OVER_BLINK = 2'd2,
        S_OVER_WAIT  = 2'd3
    } gui_state_t;

    localparam int unsigned H_RANGE = 640;
    localparam int unsigned V_RANGE = 480;

    // Overlay ROMs use this colour as "transparent"; upstream turns it into *_on.
    localparam logic [11:0] RGB_TRANSPARENT = 12'hFF0;

endpackage

// File: rtl/gui_pixel_mux.sv
// Registered fixed-priority pixel compositor: blanking, title overlay,
// game-over overlay, then the game layer.
module gui_pixel_mux #(
    parameter int unsigned RGB_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             video_on,
    input  logic             title_vis,
    input  logic             title_on,
    input  logic [RGB_W-1:0] title_rgb,
    input  logic             over_vis,
    input  logic             over_on,
    input  logic [RGB_W-1:0] over_rgb,
    input  logic [RGB_W-1:0] game_rgb,
    output logic [RGB_W-1:0] rgb_out
);

    logic [RGB_W-1:0] rgb_d;

    always_comb begin
        rgb_d = game_rgb;
        if (!video_on) begin
            rgb_d = '0;
        end else if (title_vis && title_on) begin
            rgb_d = title_rgb;
        end else if (over_vis && over_on) begin
            rgb_d = over_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out <= '0;
        end else begin
            rgb_out <= rgb_d;
        end
    end

endmodule

// File: rtl/gui_screen_ctrl.sv
// GUI screen sequencer: title -> play -> game-over blink -> game-over wait,
// gating the game logic and compositing the overlay layers.
module gui_screen_ctrl
    import gui_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 120,
    parameter int unsigned BLINK_SHIFT  = 3,
    parameter int unsigned RGB_W        = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             start_btn,
    input  logic             game_over_evt,
    input  logic             video_on,
    input  logic [RGB_W-1:0] game_rgb,
    input  logic [RGB_W-1:0] title_rgb,
    input  logic             title_on,
    input  logic [RGB_W-1:0] over_rgb,
    input  logic             over_on,
    output logic [RGB_W-1:0] rgb_out,
    output logic             game_run,
    output logic             game_rst,
    output logic [1:0]       state
);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    gui_state_t cur_state;
    logic [7:0] frame_cnt;
    logic       start_q;
    logic       start_edge;
    logic       title_vis;
    logic       over_vis;

    assign start_edge = start_btn & ~start_q;
    assign state      = cur_state;

    // start_q resets high so a button held through reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_TITLE;
            frame_cnt <= '0;
            start_q   <= 1'b1;
            game_run  <= 1'b0;
            game_rst  <= 1'b0;
        end else begin
            start_q  <= start_btn;
            game_rst <= 1'b0;
            case (cur_state)
                S_TITLE: begin
                    game_run <= 1'b0;
                    if (start_edge) begin
                        cur_state <= S_PLAY;
                        game_rst  <= 1'b1;
                        game_run  <= 1'b1;
                    end
                end
                S_PLAY: begin
                    game_run <= 1'b1;
                    if (game_over_evt) begin
                        cur_state <= S_OVER_BLINK;
                        game_run  <= 1'b0;
                        frame_cnt <= '0;
                    end
                end
                S_OVER_BLINK: begin
                    game_run <= 1'b0;
                    if (frame_tick) begin
                        if (frame_cnt == BLINK_LAST) begin
                            cur_state <= S_OVER_WAIT;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                S_OVER_WAIT: begin
                    game_run <= 1'b0;
                    if (start_edge) begin
                        cur_state <= S_PLAY;
                        game_rst  <= 1'b1;
                        game_run  <= 1'b1;
                    end
                end
                default: begin
                    cur_state <= S_TITLE;
                    game_run  <= 1'b0;
                end
            endcase
        end
    end

    // Visibility reads the live state register, so a phase change shows on the next pixel.
    always_comb begin
        title_vis = (cur_state == S_TITLE);
        over_vis  = (cur_state == S_OVER_WAIT) ||
                    ((cur_state == S_OVER_BLINK) && !frame_cnt[BLINK_SHIFT]);
    end

    gui_pixel_mux #(
        .RGB_W (RGB_W)
    ) u_pixel_mux (
        .clk       (clk),
        .rst       (rst),
        .video_on  (video_on),
        .title_vis (title_vis),
        .title_on  (title_on),
        .title_rgb (title_rgb),
        .over_vis  (over_vis),
        .over_on   (over_on),
        .over_rgb  (over_rgb),
        .game_rgb  (game_rgb),
        .rgb_out   (rgb_out)
    );

endmodule

// File: tb/tb_gui_screen_ctrl.sv
module tb_gui_screen_ctrl;

  typedef enum {K_STATE, K_RUN, K_RST, K_RGB} chk_kind_t;

  typedef struct {
    int          at;
    chk_kind_t   kind;
    logic [11:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        start_btn;
  logic        game_over_evt;
  logic        video_on;
  logic [11:0] game_rgb;
  logic [11:0] title_rgb;
  logic        title_on;
  logic [11:0] over_rgb;
  logic        over_on;
  logic [11:0] rgb_out;
  logic        game_run;
  logic        game_rst;
  logic [1:0]  state;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gui_screen_ctrl #(
    .BLINK_FRAMES (120),
    .BLINK_SHIFT  (3),
    .RGB_W        (12)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .start_btn     (start_btn),
    .game_over_evt (game_over_evt),
    .video_on      (video_on),
    .game_rgb      (game_rgb),
    .title_rgb     (title_rgb),
    .title_on      (title_on),
    .over_rgb      (over_rgb),
    .over_on       (over_on),
    .rgb_out       (rgb_out),
    .game_run      (game_run),
    .game_rst      (game_rst),
    .state         (state)
  );

  task automatic expect_nx(input int d, input chk_kind_t k, input logic [11:0] v,
                           input string nm);
    exp_t e;
    e.at   = cyc + d;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  function automatic logic [11:0] blink_rgb(input int f);
    return ((f / 8) % 2 == 0) ? 12'hF00 : 12'h0F0;
  endfunction

  initial begin
    int          i;
    logic [11:0] act;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      i = 0;
      while (i < q.size()) begin
        if (q[i].at <= cyc) begin
          case (q[i].kind)
            K_STATE: act = {10'b0, state};
            K_RUN:   act = {11'b0, game_run};
            K_RST:   act = {11'b0, game_rst};
            default: act = rgb_out;
          endcase
          checks++;
          if (q[i].at != cyc || act !== q[i].val) begin
            errors++;
            $display("FAIL %s cyc %0d: got %h expected %h", q[i].name, cyc,
                     act, q[i].val);
          end
          q.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start_btn = 1'b1; frame_tick = 1'b0; game_over_evt = 1'b0;
    video_on = 1'b0; game_rgb = '0; title_rgb = '0; title_on = 1'b0;
    over_rgb = '0; over_on = 1'b0;

    @(negedge clk);
    expect_nx(1, K_STATE, 12'h0, "rst_state");
    expect_nx(1, K_RUN,   12'h0, "rst_run");
    expect_nx(1, K_RST,   12'h0, "rst_gamerst");
    expect_nx(1, K_RGB,   12'h0, "rst_rgb");
    @(negedge clk);
    rst = 1'b0;

    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      expect_nx(1, K_STATE, 12'h0, "held_state");
      expect_nx(1, K_RST,   12'h0, "held_gamerst");
      repeat (4) begin
        @(negedge clk);
        frame_tick = 1'b0;
        expect_nx(1, K_STATE, 12'h0, "held_state");
        expect_nx(1, K_RST,   12'h0, "held_gamerst");
      end
    end

    @(negedge clk);
    start_btn = 1'b0;
    expect_nx(1, K_STATE, 12'h0, "release_state");
    @(negedge clk);
    start_btn = 1'b1;
    expect_nx(1, K_STATE, 12'h1, "start_state");
    expect_nx(1, K_RST,   12'h1, "start_gamerst");
    expect_nx(1, K_RUN,   12'h1, "start_run");
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || game_rst !== 1'b1 || game_run !== 1'b1) begin
      errors++;
      $display("FAIL inline_start: state %0d game_rst %b game_run %b", state, game_rst,
               game_run);
    end
    expect_nx(1, K_STATE, 12'h1, "play_state");
    expect_nx(1, K_RST,   12'h0, "gamerst_one_cycle");
    expect_nx(1, K_RUN,   12'h1, "play_run");

    @(negedge clk);
    checks++;
    if (game_rst !== 1'b0) begin
      errors++;
      $display("FAIL inline_gamerst_one_cycle: game_rst %b", game_rst);
    end
    start_btn = 1'b0;
    @(negedge clk);
    start_btn = 1'b1;
    expect_nx(1, K_STATE, 12'h1, "play_ignore_start");
    expect_nx(1, K_RST,   12'h0, "play_no_gamerst");

    @(negedge clk);
    video_on = 1'b1; over_on = 1'b1; over_rgb = 12'hF00; game_rgb = 12'h0F0;
    game_over_evt = 1'b1;
    expect_nx(1, K_STATE, 12'h2, "over_state");
    expect_nx(1, K_RUN,   12'h0, "over_run");
    expect_nx(1, K_RGB,   12'h0F0, "play_rgb");
    @(negedge clk);
    game_over_evt = 1'b0;

    for (int f = 0; f < 120; f++) begin
      expect_nx(1, K_RGB,   blink_rgb(f), "blink_rgb");
      expect_nx(1, K_STATE, 12'h2, "blink_state");
      @(negedge clk);
      frame_tick = 1'b1;
      expect_nx(1, K_STATE, (f == 119) ? 12'h3 : 12'h2, "blink_tick_state");
      @(negedge clk);
      frame_tick = 1'b0;
    end
    checks++;
    if (state !== 2'd3 || game_run !== 1'b0) begin
      errors++;
      $display("FAIL inline_wait: state %0d game_run %b", state, game_run);
    end
    expect_nx(1, K_STATE, 12'h3, "wait_state");
    expect_nx(1, K_RGB,   12'hF00, "wait_rgb");

    @(negedge clk);
    start_btn = 1'b0;
    expect_nx(1, K_STATE, 12'h3, "wait_hold");
    @(negedge clk);
    start_btn = 1'b1;
    expect_nx(1, K_STATE, 12'h1, "wait_start_state");
    expect_nx(1, K_RST,   12'h1, "wait_start_gamerst");
    expect_nx(1, K_RUN,   12'h1, "wait_start_run");
    @(negedge clk);
    expect_nx(1, K_RST,   12'h0, "wait_gamerst_one_cycle");
    expect_nx(1, K_RGB,   12'h0F0, "replay_rgb");

    @(negedge clk);
    start_btn = 1'b0;
    @(negedge clk);
    start_btn = 1'b1; game_over_evt = 1'b1; frame_tick = 1'b1;
    expect_nx(1, K_STATE, 12'h2, "coinc_state");
    expect_nx(1, K_RST,   12'h0, "coinc_gamerst");
    expect_nx(1, K_RUN,   12'h0, "coinc_run");
    @(negedge clk);
    game_over_evt = 1'b0; frame_tick = 1'b0;
    expect_nx(1, K_STATE, 12'h2, "coinc_hold");
    expect_nx(1, K_RGB,   12'hF00, "coinc_cnt0");
    do_ticks(7);
    expect_nx(1, K_RGB,   12'hF00, "blink_cnt7");
    do_ticks(1);
    expect_nx(1, K_RGB,   12'h0F0, "blink_cnt8");
    do_ticks(42);
    expect_nx(1, K_RGB,   12'hF00, "blink_cnt50");
    expect_nx(1, K_STATE, 12'h2, "blink_cnt50_state");

    @(negedge clk);
    rst = 1'b1;
    expect_nx(1, K_STATE, 12'h0, "midrst_state");
    expect_nx(1, K_RUN,   12'h0, "midrst_run");
    expect_nx(1, K_RST,   12'h0, "midrst_gamerst");
    expect_nx(1, K_RGB,   12'h0, "midrst_rgb");
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || game_run !== 1'b0 || rgb_out !== 12'h000) begin
      errors++;
      $display("FAIL inline_midrst: state %0d game_run %b rgb %h", state, game_run,
               rgb_out);
    end
    rst = 1'b0;
    expect_nx(1, K_STATE, 12'h0, "post_rst_no_edge");
    expect_nx(1, K_RST,   12'h0, "post_rst_gamerst");
    expect_nx(1, K_RGB,   12'h0F0, "title_game_rgb");

    @(negedge clk);
    title_on = 1'b1; title_rgb = 12'h00F;
    expect_nx(1, K_RGB, 12'h00F, "title_rgb");
    @(negedge clk);
    title_on = 1'b0;
    expect_nx(1, K_RGB, 12'h0F0, "title_off_rgb");
    @(negedge clk);
    video_on = 1'b0; title_on = 1'b1;
    expect_nx(1, K_RGB, 12'h000, "blank_rgb");
    @(negedge clk);
    video_on = 1'b1; title_on = 1'b0; start_btn = 1'b0;
    expect_nx(1, K_RGB, 12'h0F0, "unblank_rgb");

    @(negedge clk);
    start_btn = 1'b1;
    expect_nx(1, K_STATE, 12'h1, "restart_state");
    expect_nx(1, K_RST,   12'h1, "restart_gamerst");
    expect_nx(1, K_RUN,   12'h1, "restart_run");
    @(negedge clk);
    expect_nx(1, K_RST,   12'h0, "restart_gamerst_end");
    expect_nx(1, K_STATE, 12'h1, "restart_hold");

    repeat (4) @(negedge clk);
    while (q.size() > 0) begin
      errors++;
      $display("FAIL %s: got no sample expected %h at cyc %0d", q[0].name, q[0].val,
               q[0].at);
      q.delete(0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gui_screen_ctrl.md
Name: gui_screen_ctrl

Overview:
- Top-level GUI screen sequencer for the 640x480 VGA path. It moves the game through four phases: title, play, game-over blink and game-over wait.
- It gates the game logic (run enable plus a one-cycle restart pulse).
- It composites the title and game-over ROM overlay layers over the game pixel stream, using one registered pixel mux stage.

Parameters:
- BLINK_FRAMES, 120: number of frame_tick pulses spent in the game-over blink phase; legal range 2..255.
- BLINK_SHIFT, 3: the overlay toggles visibility every 2^BLINK_SHIFT frames during blink; legal range 0..6.
- RGB_W, 12: pixel colour width.

Ports:
- clk  in  1  pixel clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse once per frame, at the start of vblank.
- start_btn  in  1  debounced start button level.
- game_over_evt  in  1  one-cycle pulse from game logic when the player dies.
- video_on  in  1  high inside the 640x480 active area (aligned with the *_on/rgb inputs).
- game_rgb  in  RGB_W  game-layer pixel.
- title_rgb  in  RGB_W  title overlay pixel.
- title_on  in  1  title overlay opaque at this pixel.
- over_rgb  in  RGB_W  game-over overlay pixel.
- over_on  in  1  game-over overlay opaque at this pixel.
- rgb_out  out  RGB_W  composited pixel, registered.
- game_run  out  1  game logic enable.
- game_rst  out  1  one-cycle restart pulse to game logic.
- state  out  2  current state, for debug and LEDs.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state=S_TITLE, frame_cnt=0, start_q=1, game_run=0, game_rst=0, rgb_out=0.
  - Setting start_q=1 means a start button held through reset never generates an edge.
- Start edge: start_edge = start_btn & ~start_q. start_q is registered every cycle.
- States and transitions (all registered; outputs change the cycle after the cause):
  - S_TITLE(0): start_edge -> S_PLAY, with game_rst=1 for exactly one cycle and game_run=1.
  - S_PLAY(1): game_run=1. game_over_evt -> S_OVER_BLINK, with game_run=0 and frame_cnt=0. start_edge is ignored.
  - S_OVER_BLINK(2): frame_cnt increments on each frame_tick. On a frame_tick with frame_cnt==BLINK_FRAMES-1 -> S_OVER_WAIT and frame_cnt=0. start_edge is ignored.
  - S_OVER_WAIT(3): start_edge -> S_PLAY, with game_rst pulse and game_run=1.
- game_over_evt is ignored outside S_PLAY.
- If game_over_evt and start_edge occur in the same cycle in S_PLAY, game_over wins.
- A frame_tick coincident with the PLAY->BLINK transition is not counted.
- frame_cnt is 8 bits wide. It never wraps in BLINK because it is capped by the transition.
- Overlay visibility:
  - title_vis = (state==S_TITLE).
  - over_vis = (state==S_OVER_WAIT) | (state==S_OVER_BLINK & ~frame_cnt[BLINK_SHIFT]).
  - In blink, the overlay is therefore visible in frames 0..2^BLINK_SHIFT-1, hidden in the next group, and so on.
- Pixel mux: one register stage, fixed priority, sampled each clk:
  - !video_on -> 0.
  - else title_vis & title_on -> title_rgb.
  - else over_vis & over_on -> over_rgb.
  - else game_rgb.
- Pixel latency is exactly 1 clk from the inputs to rgb_out. Upstream aligns the *_on flags with ROM output latency.
- Visibility uses the state register value of the same cycle. There is no extra pipelining, so state changes take effect on the next pixel.
- Reset asserted mid-operation (any state) returns to S_TITLE next cycle, with game_run=0 and rgb_out=0.

Decomposition:
- Shared package gui_pkg:
  - State encodings S_TITLE/S_PLAY/S_OVER_BLINK/S_OVER_WAIT.
  - H_RANGE=640, V_RANGE=480.
  - RGB_TRANSPARENT=12'hFF0, the ROM key colour used by the overlay layers to derive *_on.
- One natural sub-module, gui_pixel_mux: the registered priority mux (video_on, two overlay layers, game layer).
- The FSM, edge detector and frame counter stay in gui_screen_ctrl.

Test Plan:
- Reset then idle 3 frames, start_btn held high from reset -> state stays 0, game_rst never pulses; release, press -> state=1 one cycle after the edge, game_rst high exactly 1 cycle, game_run=1.
- In S_PLAY pulse game_over_evt -> state=2, game_run=0 next cycle. Issue 119 frame_ticks -> still 2. The 120th tick -> state=3.
- Blink visibility with BLINK_SHIFT=3, over_on=1, over_rgb=12'hF00, game_rgb=12'h0F0 -> rgb_out=F00 for frames 0-7, 0F0 for frames 8-15, F00 for 16-23.
- S_PLAY with game_over_evt and start rising edge in the same cycle -> state=2, no game_rst pulse. In S_OVER_WAIT, start edge -> state=1 plus game_rst pulse.
- Pixel path: video_on=0 -> rgb_out=0. In S_TITLE, title_on=1, title_rgb=12'h00F -> rgb_out=00F one clk later. title_on=0 -> game_rgb.
- rst asserted mid-blink (frame_cnt=50) -> next cycle state=0, frame_cnt=0, game_run=0, rgb_out=0. A subsequent start edge re-enters S_PLAY normally.
